// File: rtl/camera_cfg_pkg.sv
// Shared definitions for the OV7670 SCCB configuration master.
// Holds the sensor ID, the constant register table and the FSM state type
// used by both the write engine and the table sequencer.
package camera_cfg_pkg;

  localparam logic [7:0]  SCCB_ID   = 8'h42;
  localparam logic [7:0]  COM7_ADDR = 8'h12;
  localparam int unsigned N_CFG     = 6;

  // {sub-address, data}; the COM7 soft reset must stay first.
  localparam logic [15:0] CFG_TABLE [N_CFG] = '{
    16'h1280,  // COM7 soft reset
    16'h1204,  // COM7 RGB output
    16'h40D0,  // COM15 RGB565, full range
    16'h8C00,  // RGB444 off
    16'h1100,  // CLKRC
    16'h3A04   // TSLB
  };

  // The engine walks StStart..StGap; the sequencer uses StStart to mean
  // "a write is in flight" plus StRstWait and StNext.
  typedef enum logic [2:0] {
    StIdle, StStart, StBits, StStop, StGap, StRstWait, StNext
  } cfg_state_e;

  // Table lookup by a 6-bit index; out-of-range returns zero.
  function automatic logic [15:0] cfg_entry(input logic [5:0] idx);
    cfg_entry = '0;
    for (int unsigned i = 0; i < N_CFG; i++) begin
      if (idx == 6'(i)) cfg_entry = CFG_TABLE[i];
    end
  endfunction

  // A COM7 write with bit 7 set resets the sensor and needs a settle delay.
  function automatic logic is_soft_reset(input logic [15:0] entry);
    return (entry[15:8] == COM7_ADDR) && entry[7];
  endfunction

endpackage

// File: rtl/sccb_write_engine.sv
// One SCCB 3-phase write: START, 27 data bits {ID, X, addr, X, data, X},
// STOP, then bus-free GAP. Timing is built from a quarter-bit tick.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   go              accept addr/data and start a write (only while idle)
//   addr, data      sub-address and register value
//   idle            engine has no write in progress
//   fin             one-cycle pulse on the last engine cycle of a write
//   sioc            SCCB clock
//   siod_o, siod_oe SCCB data drive value and enable
module sccb_write_engine
  import camera_cfg_pkg::*;
#(
  parameter int unsigned DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       idle,
  output logic       fin,
  output logic       sioc,
  output logic       siod_o,
  output logic       siod_oe
);

  localparam int unsigned     CntW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast   = CntW'(DIV - 1);
  localparam logic [CntW-1:0] CntPenult = CntW'((DIV > 1) ? DIV - 2 : 0);

  cfg_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      q_q, q_d;
  logic [4:0]      bit_q, bit_d;
  logic [26:0]     shift_q, shift_d;
  logic            sioc_q, sioc_d, siod_q, siod_d, oe_q, oe_d;
  logic            tick;

  assign tick = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == StIdle || tick) ? '0 : cnt_q + 1'b1;
    q_d     = q_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    fin     = 1'b0;
    case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StStart;
          q_d     = '0;
          bit_d   = '0;
          shift_d = {SCCB_ID, 1'b1, addr, 1'b1, data, 1'b1};
        end
      end
      StStart: begin
        if (tick) begin
          if (q_q == 3'd1) begin
            state_d = StBits;
            q_d     = '0;
          end else begin
            q_d = q_q + 3'd1;
          end
        end
      end
      StBits: begin
        if (tick) begin
          if (q_q == 3'd3) begin
            q_d     = '0;
            shift_d = {shift_q[25:0], 1'b1};
            if (bit_q == 5'd26) state_d = StStop;
            else                bit_d   = bit_q + 5'd1;
          end else begin
            q_d = q_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (q_q == 3'd3) begin
            state_d = StGap;
            q_d     = '0;
          end else begin
            q_d = q_q + 3'd1;
          end
        end
      end
      StGap: begin
        // End the gap one clk early; the sequencer's NEXT cycle fills it,
        // so the whole write still spans 122 quarter periods.
        fin = (DIV == 1) ? (q_q == 3'd6 && tick) : (q_q == 3'd7 && cnt_q == CntPenult);
        if (fin)       state_d = StIdle;
        else if (tick) q_d     = q_q + 3'd1;
      end
      default: state_d = StIdle;
    endcase

    // Line values decoded from the next state so the pins are registered.
    sioc_d = 1'b1;
    siod_d = 1'b1;
    oe_d   = 1'b0;
    case (state_d)
      StStart: begin
        siod_d = 1'b0;
        oe_d   = 1'b1;
      end
      StBits: begin
        sioc_d = q_d[1];
        oe_d   = !((bit_d == 5'd8) || (bit_d == 5'd17) || (bit_d == 5'd26));
        siod_d = oe_d ? shift_d[26] : 1'b1;
      end
      StStop: begin
        sioc_d = (q_d != 3'd0);
        siod_d = q_d[1];
        oe_d   = (q_d != 3'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      q_q     <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sioc_q  <= 1'b1;
      siod_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sioc_q  <= sioc_d;
      siod_q  <= siod_d;
      oe_q    <= oe_d;
    end
  end

  assign idle    = (state_q == StIdle);
  assign sioc    = sioc_q;
  assign siod_o  = siod_q;
  assign siod_oe = oe_q;

endmodule

// File: rtl/camera_sccb_config.sv
// OV7670 register-configuration master. A start pulse writes the whole
// constant table over SCCB, pausing after a COM7 soft reset; a wr_req pulse
// issues one software write. The tristate buffer and pull-up live outside.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             run the configuration table
//   wr_req            single write of wr_addr/wr_data
//   busy              any write or settle wait in progress
//   done              table finished; cleared by the next start
//   cfg_idx           table entry being sent
//   sioc, siod_o, siod_oe  SCCB pins
module camera_sccb_config
  import camera_cfg_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned SCCB_HZ    = 100_000,
  parameter int unsigned RESET_WAIT = CLK_HZ / 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic [5:0] cfg_idx,
  output logic       sioc,
  output logic       siod_o,
  output logic       siod_oe
);

  localparam int unsigned      DIV      = CLK_HZ / (4 * SCCB_HZ);
  localparam int unsigned      WaitW    = (RESET_WAIT > 1) ? $clog2(RESET_WAIT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'((RESET_WAIT > 0) ? RESET_WAIT - 1 : 0);
  localparam logic [5:0]       LastIdx  = 6'(N_CFG - 1);

  cfg_state_e       state_q, state_d;
  logic [5:0]       cfg_idx_q, cfg_idx_d;
  logic             done_q, done_d;
  logic             single_q, single_d;
  logic [15:0]      cur_q, cur_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [15:0]      go_entry;
  logic             eng_go, eng_idle, eng_fin;

  always_comb begin
    state_d   = state_q;
    cfg_idx_d = cfg_idx_q;
    done_d    = done_q;
    single_d  = single_q;
    wait_d    = wait_q;
    eng_go    = 1'b0;
    go_entry  = cur_q;
    case (state_q)
      StIdle: begin
        // The engine is always idle here; the gate just guarantees go never
        // lands on a running write.
        if (eng_idle && start) begin
          cfg_idx_d = '0;
          done_d    = 1'b0;
          single_d  = 1'b0;
          eng_go    = 1'b1;
          go_entry  = cfg_entry(6'd0);
          state_d   = StStart;
        end else if (eng_idle && wr_req) begin
          single_d = 1'b1;
          eng_go   = 1'b1;
          go_entry = {wr_addr, wr_data};
          state_d  = StStart;
        end
      end
      StStart: begin
        if (eng_fin) begin
          if (is_soft_reset(cur_q)) begin
            wait_d  = '0;
            state_d = StRstWait;
          end else begin
            state_d = StNext;
          end
        end
      end
      StRstWait: begin
        if (wait_q == WaitLast) state_d = StNext;
        else                    wait_d  = wait_q + 1'b1;
      end
      StNext: begin
        if (single_q) begin
          state_d = StIdle;
        end else if (cfg_idx_q == LastIdx) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cfg_idx_d = cfg_idx_q + 6'd1;
          eng_go    = 1'b1;
          go_entry  = cfg_entry(cfg_idx_q + 6'd1);
          state_d   = StStart;
        end
      end
      default: state_d = StIdle;
    endcase
    cur_d = eng_go ? go_entry : cur_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cfg_idx_q <= '0;
      done_q    <= 1'b0;
      single_q  <= 1'b0;
      cur_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      cfg_idx_q <= cfg_idx_d;
      done_q    <= done_d;
      single_q  <= single_d;
      cur_q     <= cur_d;
      wait_q    <= wait_d;
    end
  end

  sccb_write_engine #(
    .DIV(DIV)
  ) u_engine (
    .clk    (clk),
    .rst    (rst),
    .go     (eng_go),
    .addr   (go_entry[15:8]),
    .data   (go_entry[7:0]),
    .idle   (eng_idle),
    .fin    (eng_fin),
    .sioc   (sioc),
    .siod_o (siod_o),
    .siod_oe(siod_oe)
  );

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign cfg_idx = cfg_idx_q;

endmodule

// File: doc/camera_sccb_config.md
# camera_sccb_config

Camera register-configuration master for the OV7670 capture path. On a start pulse it walks a constant table of (sub-address, data) pairs and writes each one over SCCB (3-phase write: ID, sub-address, data), inserting the mandatory settle delay after a COM7 soft reset. It also accepts single software-issued register writes. It sits upstream of the pixel-capture stage, putting the sensor in RGB565 mode and starting Xclk-driven output before capture is enabled.

## Interface
- `CLK_HZ`, 50_000_000 — frequency of `clk`.
- `SCCB_HZ`, 100_000 — SIOC bit rate; quarter-bit divider `DIV = CLK_HZ/(4*SCCB_HZ)` (125 at defaults, must be ≥1).
- `RESET_WAIT`, CLK_HZ/1000 — clk cycles to idle after a COM7 reset write (1 ms).
- `clk  in  1` system clock; one clock domain for the whole block.
- `rst  in  1` asynchronous, active-high reset.
- `start  in  1` one-cycle pulse: run the full configuration table.
- `wr_req  in  1` one-cycle pulse: single write of `wr_addr`/`wr_data`.
- `wr_addr  in  8` sub-address for a single write.
- `wr_data  in  8` data for a single write.
- `busy  out  1` high while any SCCB activity or wait is in progress.
- `done  out  1` level; set when the table completes, cleared by the next `start`.
- `cfg_idx  out  6` index of the table entry being sent.
- `sioc  out  1` SCCB clock.
- `siod_o  out  1` SCCB data drive value.
- `siod_oe  out  1` SCCB data output enable; the top-level tristate and pull-up sit outside this block.

## Operation
- Reset values: `busy`=0, `done`=0, `cfg_idx`=0, `sioc`=1, `siod_o`=1, `siod_oe`=0.
- States:
  - IDLE
  - START (SIOD low, SIOC high)
  - BITS (27 bits)
  - STOP
  - GAP
  - RSTWAIT
  - NEXT
- IDLE:
  - `start` loads `cfg_idx`=0, clears `done`, and enters START.
  - Otherwise `wr_req` latches addr/data and enters START in single mode.
  - `start` and `wr_req` in the same cycle: `start` wins and `wr_req` is dropped.
  - Both inputs are ignored when not in IDLE.
- Shift word, MSB first, 27 bits: `{SCCB_ID, X, sub_addr, X, data, X}`. `SCCB_ID`=8'h42. X is the don't-care bit: `siod_oe`=0 during it, and ACK is not checked.
- After STOP, GAP enforces bus-free time.
- Entry with addr 8'h12 and data[7]=1 then enters RSTWAIT for `RESET_WAIT` cycles.
- NEXT:
  - Table mode: increment `cfg_idx`. If `cfg_idx`==N_CFG-1 was just sent, set `done` and return to IDLE; otherwise go to START.
  - Single mode: return to IDLE without touching `done`/`cfg_idx`.
- `busy` = state≠IDLE.
- Reset mid-transaction: all outputs return asynchronously to reset values. The sensor sees both lines released; no recovery sequence is generated.

## Timing
- Quarter tick `q`: one `clk` pulse every `DIV` cycles, counted by a counter cleared when leaving IDLE.
- START: SIOD driven 0 while SIOC=1 for 2 q, then SIOC→0.
- Each bit is 4 q:
  - q0: SIOC=0, SIOD updated.
  - q1: SIOC=0.
  - q2, q3: SIOC=1.
- STOP, 4 q:
  - q0: SIOC=0, SIOD=0.
  - q1: SIOC=1.
  - q2–q3: SIOD→1, then `siod_oe`=0.
- GAP: 8 q with lines released.
- Transaction length: 2+108+4+8 = 122 q = 122·DIV clk (15250 at defaults), plus `RESET_WAIT` where it applies.
- `busy` rises the cycle after the accepted `start`/`wr_req`.
- `done` rises the same cycle `busy` falls at table end.

## Structure
- Package `camera_cfg_pkg`:
  - `SCCB_ID`.
  - `N_CFG`.
  - Constant ROM `CFG_TABLE[N_CFG]` of 16-bit `{addr,data}` entries:
    - 12/80 — COM7 reset
    - 12/04 — RGB
    - 40/D0 — COM15 RGB565 full range
    - 8C/00 — RGB444 off
    - 11/00 — CLKRC
    - 3A/04 — TSLB
  - State enum.
- Sub-module `sccb_write_engine`: one 3-phase write, with ports `go`/`addr`/`data` → `idle`/`sioc`/`siod_o`/`siod_oe`, containing the q divider and the START/BITS/STOP/GAP states.
- The top level holds the table sequencer, RSTWAIT and the single-write path.

## Test plan
Bench setup: `CLK_HZ`=400_000, `SCCB_HZ`=100_000 (`DIV`=1), `RESET_WAIT`=10.
- Reset then idle 20 cycles → `sioc`=1, `siod_oe`=0, `busy`=0, `done`=0.
- `wr_req` with addr 8'h40 / data 8'hD0 → SCCB monitor decodes ID 42, sub-address 40, data D0. `siod_oe`=0 in bits 9, 18 and 27. `busy` is high for exactly 122 cycles. `done` stays 0.
- `start` → monitor sees all N_CFG writes in table order. The first write is followed by a gap of ≥8+10 cycles with lines high. `done`=1 and `cfg_idx`=N_CFG-1 at the end.
- `start` and `wr_req` in the same cycle, then a `wr_req` while busy → only the table writes appear; no extra transaction.
- `rst` asserted at bit 14 of the second write → outputs return to reset values asynchronously. A following `start` replays the table from index 0.
- Timing checker throughout: SIOD never changes while SIOC=1, except the START falling edge and the STOP rising edge.
